cipher_frame_tx: RTL

Transmit framer that sits directly downstream of the XTEA encipher stage. It accepts 18-bit ciphertext words through a valid/ready handshake and buffers them in a small FIFO. Each word is serialized as a fixed 28-bit frame: 8-bit sync preamble, 18 data bits, even parity, stop bit. The serial line feeds the board's digital channel toward the receive/decipher side.

---
 rtl/cipher_link_pkg.sv | 30 +++
 rtl/cipher_word_fifo.sv | 79 +++++++
 rtl/cipher_frame_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cipher_link_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : cipher_link_pkg                                              |
// | Description : Shared definitions for the cipher serial link: ciphertext    |
// |               word width, sync preamble, frame length and the transmit     |
// |               FSM state type. Used by both the framer and the deframer.    |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package cipher_link_pkg;

    localparam int         CIPHER_W     = 18;
    localparam logic [7:0] SYNC_PATTERN = 8'hA5;
    localparam int         SYNC_BITS    = 8;
    // preamble + data + parity + stop
    localparam int         FRAME_BITS   = SYNC_BITS + CIPHER_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/cipher_word_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : cipher_word_fifo                                             |
// | Description : Single-clock synchronous FIFO with first-word-fall-through   |
// |               head output and an occupancy count.                          |
// | Ports       : clk, rst      - clock, synchronous active-high reset          |
// |               i_push/i_data - write strobe and data (ignored when full)    |
// |               i_pop         - remove head word (ignored when empty)        |
// |               o_head        - word at the head of the queue                |
// |               o_count       - number of stored words                       |
// |               o_full/o_empty- occupancy flags                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cipher_word_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // A full FIFO refuses the write even when a pop frees a slot this cycle.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage needs no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cipher_frame_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : cipher_frame_tx                                              |
// | Description : Serial transmit framer for XTEA ciphertext words. Buffers    |
// |               words in a FIFO and sends each as SYNC, data MSB first,      |
// |               even parity and a stop bit, BIT_DIV clocks per bit.          |
// | Ports       : clk, rst   - clock, synchronous active-high reset            |
// |               word_in    - ciphertext word                                 |
// |               word_valid - word_in valid this cycle                        |
// |               word_ready - FIFO can accept (low during rst)                |
// |               tx_bit     - registered serial line, idles high              |
// |               tx_active  - high while a frame is on the line               |
// |               frame_done - pulse in the last cycle of each stop bit        |
// |               fifo_level - buffered word count                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cipher_frame_tx
    import cipher_link_pkg::*;
#(
    parameter int         WORD_W     = CIPHER_W,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC       = SYNC_PATTERN,
    parameter int         BIT_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_W-1:0]             word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic                          tx_bit,
    output logic                          tx_active,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_FRAME_W = SYNC_BITS + WORD_W + 2;
    localparam int c_DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int c_IDX_W   = $clog2((WORD_W > SYNC_BITS) ? WORD_W : SYNC_BITS);
    localparam logic [c_DIV_W-1:0] c_LAST_DIV = c_DIV_W'(BIT_DIV - 1);

    tx_state_t            r_state;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_IDX_W-1:0]   r_bit_idx;
    // Bits still to send after the one currently on tx_bit.
    logic [c_FRAME_W-2:0] r_shift;

    logic                 w_full;
    logic                 w_empty;
    logic [WORD_W-1:0]    w_head;
    logic                 w_push;
    logic                 w_load;
    logic                 w_bit_end;
    logic [c_DIV_W-1:0]   w_div_nxt;
    logic [c_FRAME_W-1:0] w_frame;

    assign word_ready = !w_full && !rst;
    assign w_push     = word_valid && word_ready;
    assign w_bit_end  = (r_div == c_LAST_DIV);
    assign w_div_nxt  = w_bit_end ? '0 : r_div + c_DIV_W'(1);
    // Pop in IDLE, or at the end of STOP so frames run back to back.
    assign w_load     = !rst && !w_empty &&
                        ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
    assign w_frame    = {SYNC, w_head, ^w_head, 1'b1};

    cipher_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (word_in),
        .i_pop   (w_load),
        .o_head  (w_head),
        .o_count (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '1;
            tx_bit     <= 1'b1;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (r_state != ST_IDLE) begin
                r_div <= w_div_nxt;
                if (w_bit_end) begin
                    tx_bit  <= r_shift[c_FRAME_W-2];
                    r_shift <= {r_shift[c_FRAME_W-3:0], 1'b1};
                end
            end

            case (r_state)
                ST_IDLE: begin
                    tx_bit <= 1'b1;
                end
                ST_PREAMBLE: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_IDX_W'(SYNC_BITS - 1)) begin
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_IDX_W'(WORD_W - 1)) begin
                            r_bit_idx <= '0;
                            r_state   <= ST_PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= ST_STOP;
                        // With one clock per bit the stop bit is its own last cycle.
                        frame_done <= (BIT_DIV == 1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (!w_load) begin
                            r_state   <= ST_IDLE;
                            tx_bit    <= 1'b1;
                            tx_active <= 1'b0;
                        end
                    end else begin
                        frame_done <= (w_div_nxt == c_LAST_DIV);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Frame load overrides the per-bit updates above.
            if (w_load) begin
                r_state   <= ST_PREAMBLE;
                r_div     <= '0;
                r_bit_idx <= '0;
                r_shift   <= w_frame[c_FRAME_W-2:0];
                tx_bit    <= w_frame[c_FRAME_W-1];
                tx_active <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
